// File: rtl/serial_subtractor_ctrl_pkg.sv
// rtl/serial_subtractor_ctrl_pkg.sv - shared types and limits for the bit-serial subtractor
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// rtl/serial_subtractor_ctrl_if.sv - start/done handshake and operand/result bus
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/serial_subtractor_ctrl_fs_cell.sv
// rtl/serial_subtractor_ctrl_fs_cell.sv - 1-bit combinational full subtractor cell
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - sequences fs_cell over WIDTH cycles, LSB first, to compute a - b
module serial_subtractor_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_subtractor_ctrl_if.slave bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic cell_d;
  logic cell_bo;

  fs_cell u_fs_cell (
    .x   (sa_q[0]),
    .y   (sb_q[0]),
    .bin (br_q),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          sa_d    = bus.a;
          sb_d    = bus.b;
          sd_d    = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sa_d = {1'b0, sa_q[WIDTH-1:1]};
        sb_d = {1'b0, sb_q[WIDTH-1:1]};
        sd_d = {cell_d, sd_q[WIDTH-1:1]};
        br_d = cell_bo;
        // Counter parks on the last index so it never leaves 0..WIDTH-1.
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = sd_q;
  assign bus.borrow_out = br_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb/tb_serial_subtractor_ctrl.sv - scoreboard bench for serial_subtractor_ctrl and fs_cell
module tb_serial_subtractor_ctrl;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH + 1;

  typedef struct packed {
    logic             borrow;
    logic [WIDTH-1:0] diff;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic cx, cy, cb, cd, cbo;
  fs_cell u_cell (
    .x   (cx),
    .y   (cy),
    .bin (cb),
    .d   (cd),
    .bo  (cbo)
  );

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    res_t        r;
    int unsigned ai;
    int unsigned bi;
    ai       = a;
    bi       = b;
    r.borrow = (ai < bi);
    r.diff   = WIDTH'(ai - bi);
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 diff=0x%0h, expected no pending result", bus.diff);
        end else begin
          e = exp_q.pop_front();
          check("diff", 32'(bus.diff), 32'(e.diff));
          check("borrow_out", 32'(bus.borrow_out), 32'(e.borrow));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int ign_at, input logic [WIDTH-1:0] ign_a);
    int done_idx = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    exp_q.push_back(model(a, b));
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
      if (i == ign_at) begin
        bus.start = 1'b1;
        bus.a     = ign_a;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_idx == 0) done_idx = i;
      end
    end
    bus.start = 1'b0;
    check("done_latency", 32'(done_idx), 32'(LAT));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(LAT));
  endtask

  initial begin
    logic [7:0] d_tab;
    logic [7:0] bo_tab;
    logic [2:0] idx;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_diff", 32'(bus.diff), 32'd0);
    check("reset_borrow", 32'(bus.borrow_out), 32'd0);
    rst = 1'b0;

    d_tab  = 8'b1001_0110;
    bo_tab = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      {cx, cy, cb} = idx;
      #1;
      check("cell_d", 32'(cd), 32'(d_tab[idx]));
      check("cell_bo", 32'(cbo), 32'(bo_tab[idx]));
    end

    run_op(8'h5A, 8'h3C, 0, '0);
    idle(2);
    run_op(8'h00, 8'h01, 0, '0);
    idle(2);
    run_op(8'hFF, 8'hFF, 0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_busy", 32'(bus.busy), 32'd0);
      check("hold_diff", 32'(bus.diff), 32'h00);
      check("hold_borrow", 32'(bus.borrow_out), 32'd0);
    end

    run_op(8'h10, 8'h01, 3, 8'hAA);
    run_op(8'h03, 8'h05, 0, '0);
    idle(2);

    @(negedge clk);
    bus.a     = 8'h33;
    bus.b     = 8'h11;
    bus.start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    check("rst_mid_diff", 32'(bus.diff), 32'd0);
    check("rst_mid_borrow", 32'(bus.borrow_out), 32'd0);
    idle(WIDTH + 3);
    run_op(8'h80, 8'h7F, 0, '0);
    idle(2);

    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h00;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    idle(WIDTH + 3);

    repeat (20) begin
      idle($urandom_range(0, 2));
      run_op(WIDTH'($urandom), WIDTH'($urandom), 0, '0);
    end

    idle(3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
